// File: rtl/alu_mdu_pkg.sv
// +--------------------------------------------------------------------------+
// | alu_mdu_pkg : op codes, FSM states and helpers shared by alu_mdu         |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
`default_nettype none

package alu_mdu_pkg;

  typedef enum logic [4:0] {
    OP_MOVZ  = 5'd0,  OP_MOVN  = 5'd1,  OP_ADD   = 5'd2,  OP_ADDU  = 5'd3,
    OP_SUB   = 5'd4,  OP_SUBU  = 5'd5,  OP_AND   = 5'd6,  OP_OR    = 5'd7,
    OP_XOR   = 5'd8,  OP_NOR   = 5'd9,  OP_SLT   = 5'd10, OP_SLTU  = 5'd11,
    OP_SRL   = 5'd12, OP_SRA   = 5'd13, OP_SLL   = 5'd14, OP_LUI   = 5'd15,
    OP_MULT  = 5'd16, OP_MULTU = 5'd17, OP_DIV   = 5'd18, OP_DIVU  = 5'd19,
    OP_MFHI  = 5'd20, OP_MFLO  = 5'd21, OP_MTHI  = 5'd22, OP_MTLO  = 5'd23
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [4:0] OP_ILLEGAL_MIN = 5'd24;

  // Ops 16..19 (mult, multu, div, divu) go through the iterative engine.
  function automatic logic is_mdu_op(input logic [4:0] op);
    return (op[4:2] == 3'b100);
  endfunction

endpackage : alu_mdu_pkg

`default_nettype wire

// File: rtl/alu_mdu_iter.sv
// +--------------------------------------------------------------------------+
// | mdu_iter : serial shift-add multiplier / restoring divider with sign fix |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module mdu_iter
  import alu_mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             abort_i,
  input  logic             start_i,
  input  logic             is_div_i,
  input  logic             is_signed_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam logic [CNT_W-1:0] C_ITER = CNT_W'(WIDTH);

  logic               busy_q, div_q, qneg_q, rneg_q, dz_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   dvs_q;

  logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_q, w_r;
  logic [WIDTH:0]     w_mul_sum, w_rem_sh, w_rem_sub;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_step, w_prod;

  assign w_a_mag = (is_signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
  assign w_b_mag = (is_signed_i && b_i[WIDTH-1]) ? -b_i : b_i;

  // acc_q low half holds the multiplier (mul) or dividend/quotient (div).
  assign w_mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, dvs_q} : '0);
  assign w_rem_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign w_ge      = (w_rem_sh >= {1'b0, dvs_q});
  assign w_rem_sub = w_rem_sh - {1'b0, dvs_q};

  always_comb begin
    w_step = {w_mul_sum, acc_q[WIDTH-1:1]};
    if (div_q) begin
      w_step = {(w_ge ? w_rem_sub[WIDTH-1:0] : w_rem_sh[WIDTH-1:0]),
                acc_q[WIDTH-2:0], w_ge};
    end
  end

  assign w_q    = acc_q[WIDTH-1:0];
  assign w_r    = acc_q[2*WIDTH-1:WIDTH];
  assign w_prod = qneg_q ? -acc_q : acc_q;

  // Divide by zero leaves |dividend| as remainder, so the sign fix restores opr1 in HI.
  always_comb begin
    hi_o = w_prod[2*WIDTH-1:WIDTH];
    lo_o = w_prod[WIDTH-1:0];
    if (div_q) begin
      hi_o = rneg_q ? -w_r : w_r;
      lo_o = dz_q ? '1 : (qneg_q ? -w_q : w_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      div_q  <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
      cnt_q  <= '0;
      acc_q  <= '0;
      dvs_q  <= '0;
    end else if (abort_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= C_ITER;
      div_q  <= is_div_i;
      qneg_q <= is_signed_i && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
      rneg_q <= is_signed_i && is_div_i && a_i[WIDTH-1];
      dz_q   <= is_div_i && (b_i == '0);
      acc_q  <= {{WIDTH{1'b0}}, w_a_mag};
      dvs_q  <= w_b_mag;
    end else if (busy_q) begin
      if (cnt_q == '0) begin
        busy_q <= 1'b0;
      end else begin
        acc_q <= w_step;
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  assign busy_o = busy_q;
  assign done_o = busy_q && (cnt_q == '0);

endmodule : mdu_iter

`default_nettype wire

// File: rtl/alu_mdu.sv
// +--------------------------------------------------------------------------+
// | alu_mdu : registered execute-stage ALU with iterative mul/div and HI/LO  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module alu_mdu
  import alu_mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] opr1,
  input  logic [WIDTH-1:0] opr2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_wb,
  output logic             not_change
);

  localparam int SH_W = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic             valid_q, valid_d, wb_q, wb_d, nc_q, nc_d;
  logic [WIDTH-1:0] result_q, result_d, hi_q, hi_d, lo_q, lo_d;

  logic             w_accept, w_is_mdu, w_mdu_start, w_mdu_busy, w_mdu_done;
  logic [WIDTH-1:0] w_mdu_hi, w_mdu_lo, w_res;
  logic             w_wb, w_nc;
  logic [WIDTH:0]   w_add_x, w_sub_x;
  logic [SH_W-1:0]  w_sh;

  assign in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign w_accept = in_valid && in_ready && !flush;
  assign w_is_mdu = is_mdu_op(op);

  assign w_add_x = {opr1[WIDTH-1], opr1} + {opr2[WIDTH-1], opr2};
  assign w_sub_x = {opr1[WIDTH-1], opr1} - {opr2[WIDTH-1], opr2};
  assign w_sh    = opr1[SH_W-1:0];

  always_comb begin
    w_res = '0;
    w_wb  = 1'b1;
    w_nc  = 1'b0;
    case (op)
      OP_MOVZ:  begin w_res = opr1; w_nc = (opr2 != '0); end
      OP_MOVN:  begin w_res = opr1; w_nc = (opr2 == '0); end
      OP_ADD:   begin w_res = w_add_x[WIDTH-1:0]; w_nc = w_add_x[WIDTH] ^ w_add_x[WIDTH-1]; end
      OP_ADDU:  w_res = w_add_x[WIDTH-1:0];
      OP_SUB:   begin w_res = w_sub_x[WIDTH-1:0]; w_nc = w_sub_x[WIDTH] ^ w_sub_x[WIDTH-1]; end
      OP_SUBU:  w_res = w_sub_x[WIDTH-1:0];
      OP_AND:   w_res = opr1 & opr2;
      OP_OR:    w_res = opr1 | opr2;
      OP_XOR:   w_res = opr1 ^ opr2;
      OP_NOR:   w_res = ~(opr1 | opr2);
      OP_SLT:   w_res = {{(WIDTH-1){1'b0}}, ($signed(opr1) < $signed(opr2))};
      OP_SLTU:  w_res = {{(WIDTH-1){1'b0}}, (opr1 < opr2)};
      OP_SRL:   w_res = opr2 >> w_sh;
      OP_SRA:   w_res = $unsigned($signed(opr2) >>> w_sh);
      OP_SLL:   w_res = opr2 << w_sh;
      OP_LUI:   w_res = {opr2[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
      OP_MTHI, OP_MTLO: w_wb = 1'b0;
      OP_MFHI:  w_res = hi_q;
      OP_MFLO:  w_res = lo_q;
      default:  begin w_wb = 1'b0; w_nc = 1'b1; end
    endcase
  end

  assign w_mdu_start = w_accept && w_is_mdu;

  mdu_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_mdu_iter (
    .clk         (clk),
    .reset       (reset),
    .abort_i     (flush),
    .start_i     (w_mdu_start),
    .is_div_i    (op[1]),
    .is_signed_i (!op[0]),
    .a_i         (opr1),
    .b_i         (opr2),
    .busy_o      (w_mdu_busy),
    .done_o      (w_mdu_done),
    .hi_o        (w_mdu_hi),
    .lo_o        (w_mdu_lo)
  );

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    result_d = result_q;
    wb_d     = wb_q;
    nc_d     = nc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if ((state_q == S_DONE) && out_ready) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
        end
        if (w_accept) begin
          if (w_is_mdu) begin
            state_d = op[1] ? S_DIV : S_MUL;
            valid_d = 1'b0;
          end else begin
            state_d  = S_DONE;
            valid_d  = 1'b1;
            result_d = w_res;
            wb_d     = w_wb;
            nc_d     = w_nc;
            if (op == OP_MTHI) hi_d = opr1;
            if (op == OP_MTLO) lo_d = opr1;
          end
        end
      end
      S_MUL, S_DIV: begin
        if (w_mdu_done) begin
          state_d  = S_DONE;
          valid_d  = 1'b1;
          result_d = w_mdu_lo;
          wb_d     = 1'b0;
          nc_d     = 1'b0;
          hi_d     = w_mdu_hi;
          lo_d     = w_mdu_lo;
        end else if (!w_mdu_busy) begin
          // Engine idle without a done pulse cannot occur normally; recover to IDLE.
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      valid_q  <= 1'b0;
      result_q <= '0;
      wb_q     <= 1'b0;
      nc_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      wb_q     <= wb_d;
      nc_q     <= nc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_result = result_q;
  assign out_wb     = wb_q;
  assign not_change = nc_q;

endmodule : alu_mdu

`default_nettype wire

// File: tb/tb_alu_mdu.sv
// +--------------------------------------------------------------------------+
// | tb_alu_mdu : directed self-checking bench for alu_mdu (WIDTH = 32)       |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_alu_mdu;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, flush, in_valid, in_ready, out_valid, out_ready, out_wb, not_change;
  logic [4:0]   op;
  logic [W-1:0] opr1, opr2, out_result;
  int           total = 0;
  int           bad   = 0;
  int           lat;
  logic         seen;

  alu_mdu #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .opr1       (opr1),
    .opr2       (opr2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_wb     (out_wb),
    .not_change (not_change)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Present an op at a negedge, expect acceptance on the next posedge, return at the following negedge.
  task automatic send(input string tag, input logic [4:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    op = o; opr1 = a; opr2 = b; in_valid = 1'b1;
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [W-1:0] res, input logic wb, input logic nc);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_result"}, out_result, res);
    check({tag, "_wb"}, {31'd0, out_wb}, {31'd0, wb});
    check({tag, "_nc"}, {31'd0, not_change}, {31'd0, nc});
  endtask

  task automatic wait_valid(output int c);
    c = 0;
    while (out_valid !== 1'b1 && c < 200) begin
      @(negedge clk);
      c++;
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = 5'd0; opr1 = '0; opr2 = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", out_result, 32'd0);
    check("rst_wb", {31'd0, out_wb}, 32'd0);
    check("rst_nc", {31'd0, not_change}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    send("mfhi0", 5'd20, 32'h0, 32'h0);        expect_out("mfhi0", 32'h0, 1'b1, 1'b0);
    send("add_ovf", 5'd2, 32'h7FFFFFFF, 32'h1); expect_out("add_ovf", 32'h80000000, 1'b1, 1'b1);
    send("addu", 5'd3, 32'h7FFFFFFF, 32'h1);    expect_out("addu", 32'h80000000, 1'b1, 1'b0);
    send("sub_ovf", 5'd4, 32'h80000000, 32'h1); expect_out("sub_ovf", 32'h7FFFFFFF, 1'b1, 1'b1);
    send("subu", 5'd5, 32'h80000000, 32'h1);    expect_out("subu", 32'h7FFFFFFF, 1'b1, 1'b0);
    send("sra", 5'd13, 32'd4, 32'h80000000);    expect_out("sra", 32'hF8000000, 1'b1, 1'b0);
    send("sll33", 5'd14, 32'd33, 32'h40000001); expect_out("sll33", 32'h80000002, 1'b1, 1'b0);
    send("srl", 5'd12, 32'd8, 32'h80000000);    expect_out("srl", 32'h00800000, 1'b1, 1'b0);
    send("slt", 5'd10, 32'hFFFFFFFF, 32'h1);    expect_out("slt", 32'h1, 1'b1, 1'b0);
    send("sltu", 5'd11, 32'hFFFFFFFF, 32'h1);   expect_out("sltu", 32'h0, 1'b1, 1'b0);
    send("lui", 5'd15, 32'h0, 32'hABCD1234);    expect_out("lui", 32'h12340000, 1'b1, 1'b0);
    send("movz_f", 5'd0, 32'h55, 32'h3);        expect_out("movz_f", 32'h55, 1'b1, 1'b1);
    send("movz_t", 5'd0, 32'h55, 32'h0);        expect_out("movz_t", 32'h55, 1'b1, 1'b0);
    send("movn_t", 5'd1, 32'h66, 32'h3);        expect_out("movn_t", 32'h66, 1'b1, 1'b0);
    send("illegal", 5'd25, 32'hFFFF, 32'h1);    expect_out("illegal", 32'h0, 1'b0, 1'b1);

    send("mult", 5'd16, 32'hFFFFFFFF, 32'd2);
    check("mult_busy_in_ready", {31'd0, in_ready}, 32'd0);
    wait_valid(lat);
    check("mult_latency", lat, 32'd33);
    expect_out("mult", 32'hFFFFFFFE, 1'b0, 1'b0);
    send("mult_mfhi", 5'd20, 32'h0, 32'h0);     expect_out("mult_mfhi", 32'hFFFFFFFF, 1'b1, 1'b0);
    send("mult_mflo", 5'd21, 32'h0, 32'h0);     expect_out("mult_mflo", 32'hFFFFFFFE, 1'b1, 1'b0);

    send("multu", 5'd17, 32'hFFFFFFFF, 32'd2);
    wait_valid(lat);
    check("multu_latency", lat, 32'd33);
    expect_out("multu", 32'hFFFFFFFE, 1'b0, 1'b0);
    send("multu_mfhi", 5'd20, 32'h0, 32'h0);    expect_out("multu_mfhi", 32'h1, 1'b1, 1'b0);

    send("div", 5'd18, 32'hFFFFFFF9, 32'd2);
    wait_valid(lat);
    check("div_latency", lat, 32'd33);
    expect_out("div", 32'hFFFFFFFD, 1'b0, 1'b0);
    send("div_mfhi", 5'd20, 32'h0, 32'h0);      expect_out("div_mfhi", 32'hFFFFFFFF, 1'b1, 1'b0);

    send("divu0", 5'd19, 32'd5, 32'd0);
    wait_valid(lat);
    expect_out("divu0", 32'hFFFFFFFF, 1'b0, 1'b0);
    send("divu0_mfhi", 5'd20, 32'h0, 32'h0);    expect_out("divu0_mfhi", 32'h5, 1'b1, 1'b0);

    send("divmin", 5'd18, 32'h80000000, 32'hFFFFFFFF);
    wait_valid(lat);
    expect_out("divmin", 32'h80000000, 1'b0, 1'b0);
    send("divmin_mfhi", 5'd20, 32'h0, 32'h0);   expect_out("divmin_mfhi", 32'h0, 1'b1, 1'b0);

    send("and_stall", 5'd6, 32'hF0F0F0F0, 32'h0FF00FF0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      expect_out("stall", 32'h00F000F0, 1'b1, 1'b0);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("stall_drain", {31'd0, out_valid}, 32'd0);

    send("b2b_or", 5'd7, 32'h00FF0000, 32'h0000FF00);  expect_out("b2b_or", 32'h00FFFF00, 1'b1, 1'b0);
    send("b2b_xor", 5'd8, 32'hFFFF0000, 32'h0F0F0F0F); expect_out("b2b_xor", 32'hF0F00F0F, 1'b1, 1'b0);
    send("b2b_nor", 5'd9, 32'hF0000000, 32'h0000000F); expect_out("b2b_nor", 32'h0FFFFFF0, 1'b1, 1'b0);

    send("mthi", 5'd22, 32'h12345678, 32'h0);   expect_out("mthi", 32'h0, 1'b0, 1'b0);
    send("div_flush", 5'd18, 32'd100, 32'd3);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen = 1'b1;
    end
    check("flush_no_result", {31'd0, seen}, 32'd0);
    send("flush_mfhi", 5'd20, 32'h0, 32'h0);    expect_out("flush_mfhi", 32'h12345678, 1'b1, 1'b0);

    send("mult_rst", 5'd16, 32'd3, 32'd5);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("mrst_valid", {31'd0, out_valid}, 32'd0);
    check("mrst_result", out_result, 32'd0);
    check("mrst_wb", {31'd0, out_wb}, 32'd0);
    check("mrst_nc", {31'd0, not_change}, 32'd0);
    send("mrst_mfhi", 5'd20, 32'h0, 32'h0);     expect_out("mrst_mfhi", 32'h0, 1'b1, 1'b0);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_alu_mdu

`default_nettype wire
